// File: rtl/nf2_dma_sys_ctrl.sv
// DMA system-side controller: tx FIFO requests/data to CPU queues, rx packets back.
// Statistics counters are built only when NF2_DMA_SYS_CTRL_STATS_EN is defined.
module nf2_dma_sys_ctrl #(
  parameter int DMA_DATA_WIDTH = 32,
  parameter int NUM_CPU_QUEUES = 4
) (
  input  logic                      sys_clk,
  input  logic                      sys_reset_n,
  input  logic                      txfifo_empty,
  input  logic [DMA_DATA_WIDTH+3:0] txfifo_rd_data,
  output logic                      txfifo_rd_inc,
  input  logic                      rxfifo_nearly_full,
  output logic                      rxfifo_wr,
  output logic [DMA_DATA_WIDTH+2:0] rxfifo_wr_data,
  output logic [NUM_CPU_QUEUES-1:0] cpu_q_dma_wr,
  output logic [DMA_DATA_WIDTH+2:0] cpu_q_dma_wr_data,
  input  logic [NUM_CPU_QUEUES-1:0] cpu_q_dma_nearly_full,
  input  logic [NUM_CPU_QUEUES-1:0] cpu_q_dma_pkt_avail,
  input  logic [NUM_CPU_QUEUES-1:0] cpu_q_dma_rd_vld,
  input  logic [NUM_CPU_QUEUES*(DMA_DATA_WIDTH+3)-1:0] cpu_q_dma_rd_data,
  output logic [NUM_CPU_QUEUES-1:0] cpu_q_dma_rd,
  output logic                      busy,
  output logic [15:0]               tx_pkt_cnt,
  output logic [15:0]               rx_pkt_cnt,
  output logic [15:0]               err_cnt
);

  localparam int W  = DMA_DATA_WIDTH;
  localparam int N  = NUM_CPU_QUEUES;
  localparam int WW = W + 3;
  localparam logic [4:0] NQ = 5'(N);

  typedef enum logic [1:0] {
    IDLE,
    TX_PKT,
    RX_PKT
  } state_e;

  state_e          state_q;
  logic [3:0]      qid_q;
  logic [N-1:0]    wr_q;
  logic [WW-1:0]   wr_data_q;
  logic            rxwr_q;
  logic [WW-1:0]   rxd_q;

  logic            head_req;
  logic            head_flag;
  logic [3:0]      head_qid;
  logic [N-1:0]    qoh;
  logic [N-1:0]    hoh;
  logic            q_nf;
  logic            q_vld;
  logic            h_avail;
  logic            h_bad;
  logic [WW-1:0]   rd_word;
  logic            tx_pop;
  logic            rx_pop;
  logic            trunc;

  assign head_req  = txfifo_rd_data[W+3];
  assign head_flag = txfifo_rd_data[W+2];
  assign head_qid  = txfifo_rd_data[3:0];

  // Out-of-range ids shift the one-hot mask to zero, so selects stay safe.
  assign qoh     = N'(1) << qid_q;
  assign hoh     = N'(1) << head_qid;
  assign q_nf    = |(cpu_q_dma_nearly_full & qoh);
  assign q_vld   = |(cpu_q_dma_rd_vld & qoh);
  assign h_avail = |(cpu_q_dma_pkt_avail & hoh);
  assign h_bad   = {1'b0, head_qid} >= NQ;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N; i++) begin
      if (qoh[i]) rd_word = cpu_q_dma_rd_data[i*WW +: WW];
    end
  end

  always_comb begin
    tx_pop = 1'b0;
    rx_pop = 1'b0;
    trunc  = 1'b0;
    unique case (state_q)
      IDLE:   tx_pop = !txfifo_empty;
      TX_PKT: begin
        tx_pop = !txfifo_empty && !head_req && !q_nf;
        trunc  = !txfifo_empty && head_req;
      end
      RX_PKT: rx_pop = q_vld && !rxfifo_nearly_full;
      default: ;
    endcase
  end

  assign txfifo_rd_inc     = tx_pop;
  assign cpu_q_dma_rd      = rx_pop ? qoh : '0;
  assign busy              = state_q != IDLE;
  assign cpu_q_dma_wr      = wr_q;
  assign cpu_q_dma_wr_data = wr_data_q;
  assign rxfifo_wr         = rxwr_q;
  assign rxfifo_wr_data    = rxd_q;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= IDLE;
      qid_q     <= '0;
      wr_q      <= '0;
      wr_data_q <= '0;
      rxwr_q    <= 1'b0;
      rxd_q     <= '0;
    end else begin
      wr_q   <= '0;
      rxwr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_pop && head_req) begin
            qid_q <= head_qid;
            if (!h_bad) begin
              if (!head_flag)  state_q <= TX_PKT;
              else if (h_avail) state_q <= RX_PKT;
            end
          end
        end
        TX_PKT: begin
          if (tx_pop) begin
            wr_q      <= qoh;
            wr_data_q <= txfifo_rd_data[W+2:0];
            if (head_flag) state_q <= IDLE;
          end else if (trunc) begin
            state_q <= IDLE;
          end
        end
        RX_PKT: begin
          if (rx_pop) begin
            rxwr_q <= 1'b1;
            rxd_q  <= rd_word;
            if (rd_word[W+2]) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef NF2_DMA_SYS_CTRL_STATS_EN
  logic        err_inc;
  logic        tx_done;
  logic        rx_done;
  logic [15:0] tx_cnt_q;
  logic [15:0] rx_cnt_q;
  logic [15:0] err_cnt_q;

  assign err_inc = trunc ||
    (state_q == IDLE && tx_pop &&
     (!head_req || h_bad || (head_flag && !h_avail)));
  assign tx_done = state_q == TX_PKT && tx_pop && head_flag;
  assign rx_done = rx_pop && rd_word[W+2];

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      if (tx_done && tx_cnt_q != 16'hFFFF)   tx_cnt_q  <= tx_cnt_q + 16'd1;
      if (rx_done && rx_cnt_q != 16'hFFFF)   rx_cnt_q  <= rx_cnt_q + 16'd1;
      if (err_inc && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign tx_pkt_cnt = tx_cnt_q;
  assign rx_pkt_cnt = rx_cnt_q;
  assign err_cnt    = err_cnt_q;
`else
  assign tx_pkt_cnt = '0;
  assign rx_pkt_cnt = '0;
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_nf2_dma_sys_ctrl.sv
// Directed bench for nf2_dma_sys_ctrl: tx, rx, back-pressure, errors,
// truncation and mid-packet reset, with queue models for both FIFO sides.
module tb_nf2_dma_sys_ctrl;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int WW = W + 3;
`ifdef NF2_DMA_SYS_CTRL_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            txfifo_empty = 1'b1;
  logic [W+3:0]    txfifo_rd_data = '0;
  logic            txfifo_rd_inc;
  logic            rxfifo_nearly_full = 1'b0;
  logic            rxfifo_wr;
  logic [WW-1:0]   rxfifo_wr_data;
  logic [N-1:0]    cpu_q_dma_wr;
  logic [WW-1:0]   cpu_q_dma_wr_data;
  logic [N-1:0]    cpu_q_dma_nearly_full = '0;
  logic [N-1:0]    cpu_q_dma_pkt_avail = '0;
  logic [N-1:0]    cpu_q_dma_rd_vld = '0;
  logic [N*WW-1:0] cpu_q_dma_rd_data = '0;
  logic [N-1:0]    cpu_q_dma_rd;
  logic            busy;
  logic [15:0]     tx_pkt_cnt;
  logic [15:0]     rx_pkt_cnt;
  logic [15:0]     err_cnt;

  nf2_dma_sys_ctrl #(.DMA_DATA_WIDTH(W), .NUM_CPU_QUEUES(N)) dut (
    .sys_clk               (clk),
    .sys_reset_n           (rst_n),
    .txfifo_empty          (txfifo_empty),
    .txfifo_rd_data        (txfifo_rd_data),
    .txfifo_rd_inc         (txfifo_rd_inc),
    .rxfifo_nearly_full    (rxfifo_nearly_full),
    .rxfifo_wr             (rxfifo_wr),
    .rxfifo_wr_data        (rxfifo_wr_data),
    .cpu_q_dma_wr          (cpu_q_dma_wr),
    .cpu_q_dma_wr_data     (cpu_q_dma_wr_data),
    .cpu_q_dma_nearly_full (cpu_q_dma_nearly_full),
    .cpu_q_dma_pkt_avail   (cpu_q_dma_pkt_avail),
    .cpu_q_dma_rd_vld      (cpu_q_dma_rd_vld),
    .cpu_q_dma_rd_data     (cpu_q_dma_rd_data),
    .cpu_q_dma_rd          (cpu_q_dma_rd),
    .busy                  (busy),
    .tx_pkt_cnt            (tx_pkt_cnt),
    .rx_pkt_cnt            (rx_pkt_cnt),
    .err_cnt               (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  oh;
    logic [WW-1:0] d;
    int            cyc;
  } ent_t;

  logic [W+3:0]  txq[$];
  logic [WW-1:0] rxq[$];
  ent_t          txlog[$];
  ent_t          rxlog[$];
  int            rxqid = 1;
  int            cyc = 0;
  logic          tx_pp = 1'b0;
  logic          rx_pp = 1'b0;
  int            nchk = 0;
  int            nfail = 0;

  always @(posedge clk) begin
    tx_pp <= txfifo_rd_inc;
    rx_pp <= |cpu_q_dma_rd;
  end

  always @(negedge clk) begin
    cyc++;
    if (tx_pp && txq.size() > 0) void'(txq.pop_front());
    if (rx_pp && rxq.size() > 0) void'(rxq.pop_front());
    if (|cpu_q_dma_wr) txlog.push_back('{cpu_q_dma_wr, cpu_q_dma_wr_data, cyc});
    if (rxfifo_wr) rxlog.push_back('{4'b0001, rxfifo_wr_data, cyc});
    txfifo_empty   = txq.size() == 0;
    txfifo_rd_data = (txq.size() == 0) ? '0 : txq[0];
    cpu_q_dma_rd_vld  = '0;
    cpu_q_dma_rd_data = '0;
    if (rxq.size() > 0) begin
      cpu_q_dma_rd_vld[rxqid] = 1'b1;
      cpu_q_dma_rd_data[rxqid*WW +: WW] = rxq[0];
    end
  end

  function automatic logic [W+3:0] dw(input logic eop, input logic [1:0] bc,
                                      input logic [W-1:0] d);
    return {1'b0, eop, bc, d};
  endfunction

  function automatic logic [W+3:0] rq(input logic rx, input logic [3:0] q);
    return {1'b1, rx, 2'b00, 28'd0, q};
  endfunction

  function automatic logic [15:0] cx(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      step(1);
      if (txq.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    step(2);
  endtask

  task automatic test_reset;
    nchk++;
    if (busy !== 1'b0 || cpu_q_dma_wr !== '0 || rxfifo_wr !== 1'b0 ||
        cpu_q_dma_rd !== '0 || txfifo_rd_inc !== 1'b0) begin
      nfail++;
      $display("FAIL reset_strobes: busy=%b wr=%b rxwr=%b rd=%b inc=%b want all 0",
               busy, cpu_q_dma_wr, rxfifo_wr, cpu_q_dma_rd, txfifo_rd_inc);
    end
    nchk++;
    if (cpu_q_dma_wr_data !== '0 || rxfifo_wr_data !== '0) begin
      nfail++;
      $display("FAIL reset_data: wr_data=%h rx_data=%h want 0",
               cpu_q_dma_wr_data, rxfifo_wr_data);
    end
    nchk++;
    if (tx_pkt_cnt !== 16'd0 || rx_pkt_cnt !== 16'd0 || err_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL reset_cnt: tx=%0d rx=%0d err=%0d want 0",
               tx_pkt_cnt, rx_pkt_cnt, err_cnt);
    end
  endtask

  task automatic test_tx;
    logic [W+3:0] wv[3];
    bit ok;
    wv[0] = dw(1'b0, 2'b00, 32'hA5A5_0001);
    wv[1] = dw(1'b0, 2'b00, 32'h1234_5678);
    wv[2] = dw(1'b1, 2'b10, 32'hDEAD_BEEF);
    txlog.delete();
    txq.push_back(rq(1'b0, 4'd2));
    for (int i = 0; i < 3; i++) txq.push_back(wv[i]);
    wait_idle(50, ok);
    nchk++;
    if (!ok) begin
      nfail++;
      $display("FAIL tx_timeout: fifo=%0d busy=%b want drained", txq.size(), busy);
    end
    nchk++;
    if (txlog.size() != 3) begin
      nfail++;
      $display("FAIL tx_count: got %0d writes want 3", txlog.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        nchk++;
        if (txlog[i].oh !== 4'b0100 || txlog[i].d !== wv[i][WW-1:0]) begin
          nfail++;
          $display("FAIL tx_word%0d: oh=%b d=%h want 0100 %h",
                   i, txlog[i].oh, txlog[i].d, wv[i][WW-1:0]);
        end
      end
      nchk++;
      if (txlog[2].cyc - txlog[0].cyc != 2) begin
        nfail++;
        $display("FAIL tx_b2b: span=%0d want 2", txlog[2].cyc - txlog[0].cyc);
      end
    end
    nchk++;
    if (tx_pkt_cnt !== cx(1)) begin
      nfail++;
      $display("FAIL tx_cnt: got %0d want %0d", tx_pkt_cnt, cx(1));
    end
  endtask

  task automatic test_tx_backpressure;
    logic [W+3:0] wv[4];
    bit ok;
    for (int i = 0; i < 4; i++) wv[i] = dw(i == 3, 2'(i), 32'hC0DE_0000 + 32'(i));
    txlog.delete();
    txq.push_back(rq(1'b0, 4'd2));
    for (int i = 0; i < 4; i++) txq.push_back(wv[i]);
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (txlog.size() >= 1) break;
    end
    cpu_q_dma_nearly_full[2] = 1'b1;
    step(5);
    nchk++;
    if (txq.size() != 3 || txlog.size() != 1) begin
      nfail++;
      $display("FAIL bp_hold: fifo=%0d writes=%0d want 3 1", txq.size(), txlog.size());
    end
    cpu_q_dma_nearly_full[2] = 1'b0;
    wait_idle(50, ok);
    nchk++;
    if (!ok || txlog.size() != 4) begin
      nfail++;
      $display("FAIL bp_done: ok=%b writes=%0d want 1 4", ok, txlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (txlog[i].oh !== 4'b0100 || txlog[i].d !== wv[i][WW-1:0]) begin
          nfail++;
          $display("FAIL bp_word%0d: oh=%b d=%h want 0100 %h",
                   i, txlog[i].oh, txlog[i].d, wv[i][WW-1:0]);
        end
      end
    end
    nchk++;
    if (tx_pkt_cnt !== cx(2)) begin
      nfail++;
      $display("FAIL bp_cnt: got %0d want %0d", tx_pkt_cnt, cx(2));
    end
  endtask

  task automatic test_rx;
    logic [WW-1:0] rv[4];
    bit ok;
    for (int i = 0; i < 4; i++) rv[i] = {i == 3, 2'(3 - i), 32'hBEEF_0100 + 32'(i)};
    rxlog.delete();
    rxqid = 1;
    for (int i = 0; i < 4; i++) rxq.push_back(rv[i]);
    cpu_q_dma_pkt_avail = 4'b0010;
    txq.push_back(rq(1'b1, 4'd1));
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (rxlog.size() >= 1) break;
    end
    rxfifo_nearly_full = 1'b1;
    step(2);
    rxfifo_nearly_full = 1'b0;
    wait_idle(50, ok);
    cpu_q_dma_pkt_avail = '0;
    nchk++;
    if (!ok || rxlog.size() != 4) begin
      nfail++;
      $display("FAIL rx_done: ok=%b writes=%0d want 1 4", ok, rxlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nchk++;
        if (rxlog[i].d !== rv[i]) begin
          nfail++;
          $display("FAIL rx_word%0d: d=%h want %h", i, rxlog[i].d, rv[i]);
        end
      end
      nchk++;
      if (rxlog[1].cyc - rxlog[0].cyc != 3 || rxlog[3].cyc - rxlog[1].cyc != 2) begin
        nfail++;
        $display("FAIL rx_gap: d01=%0d d13=%0d want 3 2",
                 rxlog[1].cyc - rxlog[0].cyc, rxlog[3].cyc - rxlog[1].cyc);
      end
    end
    nchk++;
    if (rx_pkt_cnt !== cx(1)) begin
      nfail++;
      $display("FAIL rx_cnt: got %0d want %0d", rx_pkt_cnt, cx(1));
    end
  endtask

  task automatic test_errors;
    bit ok;
    txlog.delete();
    txq.push_back(rq(1'b0, 4'd7));
    wait_idle(20, ok);
    nchk++;
    if (!ok || err_cnt !== cx(1)) begin
      nfail++;
      $display("FAIL err_qid: ok=%b err=%0d want 1 %0d", ok, err_cnt, cx(1));
    end
    txq.push_back(rq(1'b1, 4'd3));
    wait_idle(20, ok);
    nchk++;
    if (!ok || err_cnt !== cx(2) || rxfifo_wr !== 1'b0) begin
      nfail++;
      $display("FAIL err_rx_empty: ok=%b err=%0d want 1 %0d", ok, err_cnt, cx(2));
    end
    txq.push_back(dw(1'b1, 2'b01, 32'h0BAD_F00D));
    wait_idle(20, ok);
    nchk++;
    if (!ok || err_cnt !== cx(3) || txlog.size() != 0) begin
      nfail++;
      $display("FAIL err_stray: ok=%b err=%0d writes=%0d want 1 %0d 0",
               ok, err_cnt, txlog.size(), cx(3));
    end
  endtask

  task automatic test_truncation;
    logic [W+3:0] a;
    logic [W+3:0] b;
    logic [W+3:0] c;
    bit ok;
    a = dw(1'b0, 2'b00, 32'h0000_AAAA);
    b = dw(1'b0, 2'b00, 32'h0000_BBBB);
    c = dw(1'b1, 2'b11, 32'h0000_CCCC);
    txlog.delete();
    txq.push_back(rq(1'b0, 4'd0));
    txq.push_back(a);
    txq.push_back(b);
    txq.push_back(rq(1'b0, 4'd3));
    txq.push_back(c);
    wait_idle(50, ok);
    nchk++;
    if (!ok || txlog.size() != 3) begin
      nfail++;
      $display("FAIL trunc_done: ok=%b writes=%0d want 1 3", ok, txlog.size());
    end else begin
      nchk++;
      if (txlog[0].oh !== 4'b0001 || txlog[0].d !== a[WW-1:0] ||
          txlog[1].oh !== 4'b0001 || txlog[1].d !== b[WW-1:0]) begin
        nfail++;
        $display("FAIL trunc_part: %b %h %b %h want 0001 %h 0001 %h",
                 txlog[0].oh, txlog[0].d, txlog[1].oh, txlog[1].d,
                 a[WW-1:0], b[WW-1:0]);
      end
      nchk++;
      if (txlog[2].oh !== 4'b1000 || txlog[2].d !== c[WW-1:0]) begin
        nfail++;
        $display("FAIL trunc_next: oh=%b d=%h want 1000 %h",
                 txlog[2].oh, txlog[2].d, c[WW-1:0]);
      end
    end
    nchk++;
    if (err_cnt !== cx(4) || tx_pkt_cnt !== cx(3)) begin
      nfail++;
      $display("FAIL trunc_cnt: err=%0d tx=%0d want %0d %0d",
               err_cnt, tx_pkt_cnt, cx(4), cx(3));
    end
  endtask

  task automatic test_reset_mid_rx;
    bit seen;
    seen = 1'b0;
    rxqid = 1;
    for (int i = 0; i < 4; i++) rxq.push_back({i == 3, 2'b00, 32'h7700_0000 + 32'(i)});
    cpu_q_dma_pkt_avail = 4'b0010;
    rxfifo_nearly_full = 1'b1;
    txq.push_back(rq(1'b1, 4'd1));
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (busy) begin
        seen = 1'b1;
        break;
      end
    end
    nchk++;
    if (!seen) begin
      nfail++;
      $display("FAIL rst_enter_rx: busy=%b want 1", busy);
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    nchk++;
    if (busy !== 1'b0 || cpu_q_dma_wr !== '0 || rxfifo_wr !== 1'b0 ||
        cpu_q_dma_rd !== '0) begin
      nfail++;
      $display("FAIL rst_mid_strobes: busy=%b wr=%b rxwr=%b rd=%b want 0",
               busy, cpu_q_dma_wr, rxfifo_wr, cpu_q_dma_rd);
    end
    nchk++;
    if (tx_pkt_cnt !== 16'd0 || rx_pkt_cnt !== 16'd0 || err_cnt !== 16'd0 ||
        cpu_q_dma_wr_data !== '0 || rxfifo_wr_data !== '0) begin
      nfail++;
      $display("FAIL rst_mid_regs: tx=%0d rx=%0d err=%0d wd=%h rd=%h want 0",
               tx_pkt_cnt, rx_pkt_cnt, err_cnt, cpu_q_dma_wr_data, rxfifo_wr_data);
    end
    rxq.delete();
    cpu_q_dma_pkt_avail = '0;
    rxfifo_nearly_full = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    test_reset();
    test_tx();
    test_tx_backpressure();
    test_rx();
    test_errors();
    test_truncation();
    test_reset_mid_rx();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/nf2_dma_sys_ctrl.md
# nf2_dma_sys_ctrl

System-clock-domain DMA controller between the DMA clock-crossing FIFOs and the per-CPU-queue DMA ports of the core. It drains the tx crossing FIFO and decodes request words versus data words. Tx packets go to the addressed CPU queue. For rx requests it moves one whole packet from the addressed CPU queue into the rx crossing FIFO.

## Interface
- DMA_DATA_WIDTH, 32, packet data width per word.
- NUM_CPU_QUEUES, 4, number of CPU queues; legal queue ids are 0..NUM_CPU_QUEUES-1.
- sys_clk  in  1  system clock; the only clock.
- sys_reset_n  in  1  reset, asynchronous assert, active low.
- txfifo_empty  in  1  tx crossing FIFO empty.
- txfifo_rd_data  in  DMA_DATA_WIDTH+4  show-ahead head word: [W+3] req flag, [W+2] eop (data) or rx flag (req), [W+1:W] bytecnt, [W-1:0] data or {0, qid[3:0]}.
- txfifo_rd_inc  out  1  pop tx FIFO head.
- rxfifo_nearly_full  in  1  rx crossing FIFO nearly full.
- rxfifo_wr  out  1  rx FIFO write strobe.
- rxfifo_wr_data  out  DMA_DATA_WIDTH+3  {eop, bytecnt, data}.
- cpu_q_dma_wr  out  NUM_CPU_QUEUES  one-hot tx write to a queue.
- cpu_q_dma_wr_data  out  DMA_DATA_WIDTH+3  {eop, bytecnt, data}, shared by all queues.
- cpu_q_dma_nearly_full  in  NUM_CPU_QUEUES  per-queue tx back-pressure.
- cpu_q_dma_pkt_avail  in  NUM_CPU_QUEUES  queue holds at least one complete rx packet.
- cpu_q_dma_rd_vld  in  NUM_CPU_QUEUES  queue head word is valid (show-ahead).
- cpu_q_dma_rd_data  in  NUM_CPU_QUEUES*(DMA_DATA_WIDTH+3)  flattened head words; queue i is at slice i.
- cpu_q_dma_rd  out  NUM_CPU_QUEUES  one-hot pop of a queue head.
- busy  out  1  FSM is not in IDLE.
- tx_pkt_cnt, rx_pkt_cnt, err_cnt  out  16 each  statistics (see Configuration).

## Operation
- FSM states: IDLE, TX_PKT, RX_PKT. A registered qid holds the active queue.
- IDLE, FIFO not empty, head is a data word: pop and discard; err_cnt++.
- IDLE, FIFO not empty, head is a req word: pop and latch qid = data[3:0].
  - qid >= NUM_CPU_QUEUES: err_cnt++, stay in IDLE.
  - rx flag = 0: go to TX_PKT.
  - rx flag = 1 and pkt_avail[qid] = 1: go to RX_PKT.
  - rx flag = 1 and pkt_avail[qid] = 0: err_cnt++, stay in IDLE (no response word).
- TX_PKT: pop when !txfifo_empty && !nearly_full[qid] && head is a data word. Write the word to queue qid. On eop: tx_pkt_cnt++, go to IDLE.
- TX_PKT, head is a req word: do not pop; err_cnt++; go to IDLE, which then services that request. A truncated packet is not closed with a forced eop.
- RX_PKT: assert cpu_q_dma_rd[qid] when rd_vld[qid] && !rxfifo_nearly_full. Forward the popped word to the rx FIFO. On eop: rx_pkt_cnt++, go to IDLE.
- While in RX_PKT the tx FIFO is not popped.
- Exactly one pop per cycle at most. All one-hot outputs are zero outside their state.

## Timing
- txfifo_rd_inc and cpu_q_dma_rd are combinational from registered state, head flags and back-pressure inputs.
- cpu_q_dma_wr and cpu_q_dma_wr_data are registered, 1 cycle after the pop.
- rxfifo_wr and rxfifo_wr_data are registered, 1 cycle after cpu_q_dma_rd.
- Throughput is 1 word per cycle in TX_PKT and RX_PKT without back-pressure.
- The IDLE request decode costs 1 cycle. The first data pop can occur the cycle after the request pop.
- Back-pressure on nearly_full gives 1 in-flight registered word; producers guarantee at least 2 words of slack.
- Reset values:
  - state = IDLE, qid = 0.
  - All strobes are 0.
  - wr_data and rx data registers are 0.
  - busy = 0 and all counters = 0.
- Reset mid-packet: immediate return to IDLE. The partial packet is not completed. An in-flight registered write is dropped.
- Counters saturate at 16'hFFFF.
- Back-pressure asserted mid-packet: the FSM holds in its state with no pop and no timeout.

## Configuration
- NF2_DMA_SYS_CTRL_STATS_EN defined: tx_pkt_cnt, rx_pkt_cnt and err_cnt are implemented as described.
- Macro undefined: the three counter outputs are tied to 0 and no counter flops exist. FSM behaviour is identical.

## Test plan
- Tx: req word {1,0,00,qid=2}, then 3 data words with eop on the last, no back-pressure -> cpu_q_dma_wr = 4'b0100 on 3 consecutive cycles with matching data; eop on the 3rd; tx_pkt_cnt = 1.
- Tx back-pressure: nearly_full[2] held for 5 cycles mid-packet -> no pop for those cycles, no data loss, packet completes in order.
- Rx: req {1,1,00,qid=1}, pkt_avail[1] = 1, queue holds 4 words -> rxfifo_wr asserted 4 cycles with matching words, eop on the last, rx_pkt_cnt = 1. rxfifo_nearly_full pulsed for 2 cycles -> 2-cycle gap.
- Errors:
  - req with qid = 7 -> err_cnt = 1, IDLE.
  - rx req on an empty queue -> err_cnt = 2.
  - stray data word in IDLE -> err_cnt = 3, word discarded.
- Truncation: a req word arrives after 2 tx data words without eop -> the req is not popped in TX_PKT, err_cnt++, and the new request is then serviced.
- Reset: sys_reset_n asserted mid-RX_PKT -> next edge busy = 0, all strobes 0, counters 0.
